// File: rtl/cbb_demux_onehot.sv
// ---------------------------------------------------------------------------
// cbb_demux_onehot
//   Registered one-hot demultiplexer. One valid/ready input stream is routed
//   to one of N output lanes picked by a one-hot select. Every lane owns a
//   single-entry output buffer, so a beat accepted on one edge is visible on
//   its lane right after that edge. Beats whose select is zero or has more
//   than one bit set are always accepted, thrown away, flagged with a
//   one-cycle pulse and counted in a saturating counter.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid && in_ready
//   in_data     input payload (WIDTH)
//   in_sel      one-hot destination lane, bit k = lane k (N)
//   out_valid   lane k holds a beat (N)
//   out_ready   lane k consumer ready (N)
//   out_data    lane k payload at [WIDTH*k +: WIDTH]
//   drop_pulse  one-cycle pulse: an illegal-select beat was dropped
//   drop_cnt    total dropped beats, saturating at all-ones (CNT_WIDTH)
// ---------------------------------------------------------------------------
module cbb_demux_onehot #(
    parameter int WIDTH     = 8,
    parameter int N         = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [N-1:0]         in_sel,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [WIDTH*N-1:0]   out_data,
    output logic                 drop_pulse,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    logic         sel_ok;
    logic         accept;
    logic         drop;
    logic [N-1:0] lane_can_take;
    logic [N-1:0] lane_load;
    logic [N-1:0] lane_pop;

    // A select is legal when it is non-zero and clearing its lowest set bit
    // leaves nothing behind. Because the select is then one-hot, masking the
    // per-lane "can take a beat" vector with it and OR-reducing picks out
    // the state of the addressed lane without building an index.
    // in_ready is deliberately independent of in_valid.
    always_comb begin
        sel_ok        = (in_sel != '0) &&
                        ((in_sel & (in_sel - {{(N-1){1'b0}}, 1'b1})) == '0);
        lane_can_take = ~out_valid | out_ready;
        in_ready      = sel_ok ? |(in_sel & lane_can_take) : 1'b1;
        accept        = in_valid & in_ready & sel_ok;
        drop          = in_valid & ~sel_ok;
        lane_load     = {N{accept}} & in_sel;
        lane_pop      = out_valid & out_ready;
    end

    // Per-lane single-entry buffer. A load has priority over a pop, which
    // gives the back-to-back case (pop and load on the same edge) for free.
    // out_valid is purely registered, so it never follows out_ready
    // combinationally. Data is left untouched on a plain pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (lane_load[k]) begin
                    out_valid[k]                <= 1'b1;
                    out_data[WIDTH*k +: WIDTH]  <= in_data;
                end else if (lane_pop[k]) begin
                    out_valid[k]                <= 1'b0;
                end
            end
        end
    end

    // Drop bookkeeping: the pulse is simply the registered drop condition;
    // the counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
